// File: rtl/quad_encoder_rpm.sv
// Quadrature encoder decoder with x4 position counting, sticky
// illegal-transition flag and gated-window speed measurement in rpm.
module quad_encoder_rpm #(
   parameter int GATE_CYCLES = 25000000,
   parameter int RPM_MUL     = 60,
   parameter int RPM_W       = 15,
   parameter int CNT_W       = 16,
   parameter int POS_W       = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ticks_a,
   input  logic             ticks_b,
   input  logic             clr_pos,
   input  logic             err_clr,
   output logic [RPM_W-1:0] rpm,
   output logic             dir,
   output logic             rpm_valid,
   output logic [POS_W-1:0] pos,
   output logic             err
);

   localparam int TMR_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int MUL_W  = $clog2(RPM_MUL + 1);
   localparam int PROD_W = CNT_W + MUL_W;
   // product width wide enough to hold both |win_cnt|*RPM_MUL and the cap
   localparam int CMP_W  = (PROD_W > RPM_W) ? PROD_W : RPM_W + 1;

   localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0]        TMR_ONE  = TMR_W'(1);
   localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
   localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CMP_W-1:0]        RPM_CAP  = CMP_W'({RPM_W{1'b1}});
   localparam logic [POS_W-1:0]        POS_ONE  = POS_W'(1);

   // Magnitude of a signed window count; the most negative value maps to
   // 2^(CNT_W-1), which still fits in CNT_W unsigned bits.
   function automatic logic [CNT_W-1:0] cnt_mag(input logic signed [CNT_W-1:0] v);
      logic [CNT_W-1:0] m;
      if (v[CNT_W-1]) begin
         m = ~v + CNT_ONE;
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Scale a count magnitude to rpm, clamping at the output full scale.
   function automatic logic [RPM_W-1:0] sat_rpm(input logic [CNT_W-1:0] mag);
      logic [CMP_W-1:0] prod;
      logic [RPM_W-1:0] r;
      prod = CMP_W'(mag) * CMP_W'(RPM_MUL);
      if (prod > RPM_CAP) begin
         r = {RPM_W{1'b1}};
      end else begin
         r = prod[RPM_W-1:0];
      end
      return r;
   endfunction

   logic                     a_meta;
   logic                     a_sync;
   logic                     b_meta;
   logic                     b_sync;
   logic [1:0]               sync_fill;
   logic [1:0]               prev_ab;
   logic                     armed;
   logic [1:0]               cur_ab;
   logic                     step_up;
   logic                     step_dn;
   logic                     illegal;
   logic signed [CNT_W-1:0]  step_val;
   logic [TMR_W-1:0]         timer;
   logic                     term;
   logic signed [CNT_W-1:0]  win_cnt;

   assign cur_ab = {a_sync, b_sync};
   assign term   = (timer == TMR_LAST);

   // Two-flop synchronisers for the asynchronous encoder pins, plus a fill
   // tracker so we know when a_sync/b_sync hold a genuine pin sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_meta    <= 1'b0;
         a_sync    <= 1'b0;
         b_meta    <= 1'b0;
         b_sync    <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         a_meta    <= ticks_a;
         a_sync    <= a_meta;
         b_meta    <= ticks_b;
         b_sync    <= b_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // Previous-state register; the first real sample only arms the decoder
   // so power-up pin levels never produce a count or an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_ab <= 2'b00;
         armed   <= 1'b0;
      end else if (armed) begin
         prev_ab <= cur_ab;
      end else if (sync_fill[1]) begin
         prev_ab <= cur_ab;
         armed   <= 1'b1;
      end else begin
         prev_ab <= prev_ab;
      end
   end

   // Gray-code transition decode: +1, -1, illegal (both bits moved) or idle.
   always_comb begin
      step_up  = 1'b0;
      step_dn  = 1'b0;
      illegal  = 1'b0;
      step_val = '0;
      if (armed) begin
         case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: begin
               step_up = 1'b0;
               step_dn = 1'b0;
               illegal = 1'b0;
            end
         endcase
      end else begin
         illegal = 1'b0;
      end
      if (step_up) begin
         step_val = CNT_ONE;
      end else if (step_dn) begin
         step_val = {CNT_W{1'b1}};
      end else begin
         step_val = '0;
      end
   end

   // Position counter; clear wins over a same-cycle step, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst || clr_pos) begin
         pos <= '0;
      end else if (step_up) begin
         pos <= pos + POS_ONE;
      end else if (step_dn) begin
         pos <= pos - POS_ONE;
      end else begin
         pos <= pos;
      end
   end

   // Sticky error; a new illegal transition beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (illegal) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end else begin
         err <= err;
      end
   end

   // Free-running measurement window timer.
   always_ff @(posedge clk) begin
      if (rst || term) begin
         timer <= '0;
      end else begin
         timer <= timer + TMR_ONE;
      end
   end

   // Saturating signed window count; on the terminal cycle it restarts with
   // that cycle's step so a boundary edge lands in the new window.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt <= '0;
      end else if (term) begin
         win_cnt <= step_val;
      end else if ((step_up && (win_cnt != CNT_MAX)) ||
                   (step_dn && (win_cnt != CNT_MIN))) begin
         win_cnt <= win_cnt + step_val;
      end else begin
         win_cnt <= win_cnt;
      end
   end

   // Speed result registers, updated and strobed once per window.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpm       <= '0;
         dir       <= 1'b0;
         rpm_valid <= 1'b0;
      end else if (term) begin
         rpm       <= sat_rpm(cnt_mag(win_cnt));
         dir       <= win_cnt[CNT_W-1];
         rpm_valid <= 1'b1;
      end else begin
         rpm_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quad_encoder_rpm.sv
// Scoreboard bench for quad_encoder_rpm: stimulus pushes expected strobe
// contents (rpm, dir, cycle) and a negedge monitor pops and compares.
module tb_quad_encoder_rpm;

   logic        clk;
   logic        rst;
   logic        a_pin;
   logic        b_pin;
   logic        clr_pos;
   logic        err_clr;
   logic [14:0] rpm;
   logic        dir;
   logic        rpm_valid;
   logic [23:0] pos;
   logic        err;
   logic [7:0]  rpm8;
   logic        dir8;
   logic        rpm_valid8;
   logic [23:0] pos8;
   logic        err8;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int idx    = 0;
   logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   typedef struct {
      int rpm;
      bit dir;
      int cyc;
   } exp_t;

   exp_t q[$];
   exp_t q8[$];

   quad_encoder_rpm #(
      .GATE_CYCLES(100), .RPM_MUL(60), .RPM_W(15), .CNT_W(16), .POS_W(24)
   ) dut (
      .clk(clk), .rst(rst), .ticks_a(a_pin), .ticks_b(b_pin),
      .clr_pos(clr_pos), .err_clr(err_clr),
      .rpm(rpm), .dir(dir), .rpm_valid(rpm_valid), .pos(pos), .err(err)
   );

   quad_encoder_rpm #(
      .GATE_CYCLES(100), .RPM_MUL(60), .RPM_W(8), .CNT_W(16), .POS_W(24)
   ) dut8 (
      .clk(clk), .rst(rst), .ticks_a(a_pin), .ticks_b(b_pin),
      .clr_pos(clr_pos), .err_clr(err_clr),
      .rpm(rpm8), .dir(dir8), .rpm_valid(rpm_valid8), .pos(pos8), .err(err8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // edges since reset deasserted
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic set_pins();
      {a_pin, b_pin} = gray[idx];
   endtask

   task automatic step_fwd();
      idx = (idx + 1) % 4;
      set_pins();
      repeat (4) tick();
   endtask

   task automatic step_rev();
      idx = (idx + 3) % 4;
      set_pins();
      repeat (4) tick();
   endtask

   task automatic step_illegal();
      idx = (idx + 2) % 4;
      set_pins();
   endtask

   task automatic push(input int r, input bit d, input int c);
      exp_t e;
      exp_t e8;
      e.rpm = r;
      e.dir = d;
      e.cyc = c;
      e8 = e;
      if (r > 255) e8.rpm = 255;
      q.push_back(e);
      q8.push_back(e8);
   endtask

   // Monitor: every strobe of either DUT is matched against its queue.
   always @(negedge clk) begin
      exp_t e;
      if (rpm_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_unexpected: rpm=%0d dir=%0d at cycle %0d", rpm, dir, cyc);
         end else begin
            e = q.pop_front();
            check("rpm", rpm, e.rpm);
            check("dir", dir, e.dir);
            check("strobe_cycle", cyc, e.cyc);
         end
      end
      if (rpm_valid8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe8_unexpected: rpm=%0d dir=%0d at cycle %0d", rpm8, dir8, cyc);
         end else begin
            e = q8.pop_front();
            check("rpm8", rpm8, e.rpm);
            check("dir8", dir8, e.dir);
            check("strobe8_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      rst = 1'b1; a_pin = 1'b0; b_pin = 1'b0; clr_pos = 1'b0; err_clr = 1'b0;
      idx = 0;
      repeat (3) tick();
      check("reset_rpm", rpm, 0);
      check("reset_valid", rpm_valid, 0);
      check("reset_pos", pos, 0);
      check("reset_err", err, 0);
      rst = 1'b0;

      // ten forward steps inside window 1
      wait_until(5);
      for (int i = 0; i < 10; i++) step_fwd();
      check("fwd_pos", pos, 10);
      check("fwd_err", err, 0);
      check("rpm_hold_before", rpm, 0);
      push(600, 1'b0, 100);
      wait_until(102);
      check("rpm_valid_one_cycle", rpm_valid, 0);
      check("rpm_hold_after", rpm, 600);

      // clear, then five reverse steps with wrap; following window idle
      clr_pos = 1'b1;
      tick();
      clr_pos = 1'b0;
      check("clr_pos", pos, 0);
      wait_until(105);
      for (int i = 0; i < 5; i++) step_rev();
      check("rev_wrap_pos", pos, 24'hFFFFFB);
      push(300, 1'b1, 200);
      push(0, 1'b0, 300);
      wait_until(302);
      check("idle_rpm", rpm, 0);
      check("idle_dir", dir, 0);

      // illegal transition, clear, then illegal coincident with clear
      step_illegal();
      repeat (3) tick();
      check("illegal_err", err, 1);
      check("illegal_pos", pos, 24'hFFFFFB);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr", err, 0);
      wait_until(310);
      step_illegal();
      repeat (2) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_set_beats_clr", err, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr_again", err, 0);
      push(0, 1'b0, 400);

      // clr_pos coincident with a step, then a step on the terminal cycle
      wait_until(405);
      clr_pos = 1'b1;
      tick();
      clr_pos = 1'b0;
      for (int i = 0; i < 7; i++) step_fwd();
      check("pos_seven", pos, 7);
      wait_until(450);
      idx = (idx + 1) % 4;
      set_pins();
      repeat (2) tick();
      clr_pos = 1'b1;
      tick();
      clr_pos = 1'b0;
      check("clr_overrides_step", pos, 0);
      tick();
      check("clr_no_late_step", pos, 0);
      push(480, 1'b0, 500);
      wait_until(497);
      idx = (idx + 1) % 4;
      set_pins();
      push(60, 1'b0, 600);
      repeat (3) tick();
      check("boundary_pos", pos, 1);
      wait_until(503);
      check("boundary_old_window", rpm, 480);

      // partial window then mid-window reset with pins held at 11
      wait_until(602);
      step_fwd();
      step_illegal();
      repeat (4) tick();
      check("pre_reset_err", err, 1);
      rst = 1'b1;
      tick();
      check("midrst_rpm", rpm, 0);
      check("midrst_dir", dir, 0);
      check("midrst_pos", pos, 0);
      check("midrst_err", err, 0);
      idx = 2;
      set_pins();
      repeat (3) tick();
      rst = 1'b0;
      wait_until(6);
      check("arm_err", err, 0);
      check("arm_pos", pos, 0);
      step_fwd();
      check("arm_step_pos", pos, 1);
      push(60, 1'b0, 100);
      wait_until(103);

      check("queue_left", q.size(), 0);
      check("queue8_left", q8.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_encoder_rpm.md
QUAD_ENCODER_RPM -- requirements
Module: quad_encoder_rpm

Interface
REQ-001 Parameter GATE_CYCLES, default 25000000, measurement window length in clk cycles (1 s at 25 MHz).
REQ-002 Parameter RPM_MUL, default 60, rpm per net decoded count per window.
REQ-003 Parameter RPM_W, default 15, rpm output width.
REQ-004 Parameter CNT_W, default 16, signed window-count width.
REQ-005 Parameter POS_W, default 24, position counter width.
REQ-006 clk  in  1  single system clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ticks_a  in  1  encoder channel A, asynchronous.
REQ-009 ticks_b  in  1  encoder channel B, asynchronous.
REQ-010 clr_pos  in  1  synchronous position clear, level.
REQ-011 err_clr  in  1  clears sticky error, level.
REQ-012 rpm  out  RPM_W  magnitude of last completed window speed.
REQ-013 dir  out  1  direction of last window: 0 forward or zero, 1 reverse.
REQ-014 rpm_valid  out  1  one-cycle strobe when rpm/dir update.
REQ-015 pos  out  POS_W  two's-complement position, x4 decoded.
REQ-016 err  out  1  sticky illegal-transition flag.

Function
REQ-017 ticks_a/ticks_b SHALL each pass a 2-flop synchroniser; decode uses only synchronised values {A,B}.
REQ-018 A previous-state register SHALL hold last synchronised {A,B}; step = compare current vs previous each cycle.
REQ-019 Forward (+1): 00->01, 01->11, 11->10, 10->00; reverse (-1): the inverse transitions; unchanged: 0.
REQ-020 Both bits changing in one cycle SHALL be illegal: step 0, err set to 1 next cycle.
REQ-021 err SHALL stay 1 until err_clr is high; simultaneous illegal transition and err_clr leaves err = 1.
REQ-022 First synchronised sample after rst deasserts SHALL only load the previous-state register (armed flag): no count, no error.
REQ-023 Latency: a pin change stable before rising edge k SHALL be reflected in pos after edge k+2 (3 cycles).
REQ-024 pos SHALL add step each cycle with wrap-around modulo 2^POS_W (0 - 1 = 2^POS_W - 1).
REQ-025 clr_pos high SHALL force pos = 0 next cycle, overriding any same-cycle step.
REQ-026 Window timer SHALL count 0..GATE_CYCLES-1 then wrap to 0, free-running after reset.
REQ-027 Signed window count SHALL accumulate steps, saturating at -2^(CNT_W-1) and 2^(CNT_W-1)-1 (no wrap).
REQ-028 On terminal timer cycle: rpm <= min(|win_cnt| * RPM_MUL, 2^RPM_W - 1); dir <= (win_cnt < 0); rpm_valid = 1 for that one cycle.
REQ-029 Same terminal cycle: win_cnt SHALL load that cycle's step (0 or +/-1), so an edge at the boundary is counted in the new window, never lost or doubled.
REQ-030 Multiply SHALL use width CNT_W + ceil(log2(RPM_MUL+1)) so saturation compare never overflows.
REQ-031 rpm and dir SHALL hold between strobes; clr_pos does not affect rpm, dir or win_cnt.

Reset
REQ-032 While rst high, next edge: rpm = 0, dir = 0, rpm_valid = 0, pos = 0, err = 0, timer = 0, win_cnt = 0, synchronisers = 00, armed = 0.
REQ-033 rst asserted mid-window SHALL discard the partial window; first rpm_valid occurs GATE_CYCLES cycles after rst deasserts.

Verification (GATE_CYCLES = 100, RPM_MUL = 60 unless stated)
REQ-034 Reset, 10 forward steps 4 cycles apart in one window -> at window end rpm = 600, dir = 0, rpm_valid one cycle, pos = 10.
REQ-035 From pos = 0, 5 reverse steps -> pos = 2^24 - 5, next strobe rpm = 300, dir = 1; following idle window -> rpm = 0, dir = 0.
REQ-036 Force {A,B} 00->11 -> err = 1, pos unchanged; pulse err_clr -> err = 0.
REQ-037 RPM_W = 8, 10 forward counts in window -> rpm = 255 (saturated).
REQ-038 clr_pos coincident with forward step at pos = 7 -> pos = 0; step on terminal cycle -> old window excludes it, new window includes it.
REQ-039 Pins held at 11 through rst release -> err = 0, pos = 0; then 11->10 -> pos = 1.
